core_sync_controller: RTL and testbench
=======================================

CORE_SYNC_CONTROLLER -- requirements
Module: core_sync_controller

Interface
REQ-001 Parameter NUM_CORES, default 4, SHALL set the number of processing cores supervised; it sets the width of end_process and core_mask.
REQ-002 Parameter START_HOLD, default 2, SHALL set the number of cycles status is held at 2'b01 in the START state; legal range 1..15.
REQ-003 Parameter TIMEOUT, default 1000, SHALL set the RUN-state cycle limit before abort; value 0 disables the timeout.
REQ-004 Parameter CNT_W, default 32, SHALL set the width of cycle_count and of the internal timeout counter.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  host run request; level-sensitive, 4-phase with done.
REQ-008 core_mask  in  NUM_CORES  cores taking part in the run; sampled only on IDLE->START.
REQ-009 end_process  in  NUM_CORES  per-core end flag, driven by each core's control unit.
REQ-010 status  out  2  broadcast to all cores: 2'b00 idle, 2'b01 go, 2'b10 done.
REQ-011 end_core  out  2  broadcast abort code: 2'b10 = force endop at the next fetch4, otherwise 2'b00.
REQ-012 busy, done, error  out  1 each  run active / run complete / run ended by timeout.
REQ-013 cycle_count  out  CNT_W  number of cycles spent in the run.

Function
REQ-014 The FSM SHALL have the states IDLE, START, RUN, ABORT and DONE, and all outputs SHALL be registered.
REQ-015 IDLE: when start=1, the FSM SHALL latch core_mask, clear seen_mask and the counters, and enter START on that edge.
REQ-016 START: status SHALL be 2'b01 for exactly START_HOLD cycles and busy SHALL be 1; the FSM then enters RUN.
REQ-017 RUN: status SHALL be 2'b00 and busy SHALL be 1; seen_mask SHALL be updated each cycle as seen_mask OR (end_process AND latched mask), including during START.
REQ-018 RUN->DONE SHALL occur when the next seen_mask equals the latched mask; a mask of 0 SHALL reach DONE on the first RUN cycle.
REQ-019 RUN->ABORT SHALL occur when TIMEOUT!=0 and the timeout counter reaches TIMEOUT-1 without completion.
REQ-020 If completion and timeout occur in the same cycle, completion SHALL win: the FSM enters DONE with error=0.
REQ-021 ABORT: end_core SHALL be 2'b10 and busy SHALL be 1; the FSM SHALL enter DONE with error=1 once seen_mask equals the latched mask, and it has no exit otherwise.
REQ-022 DONE: status SHALL be 2'b10, done=1, busy=0, end_core=2'b00, and error SHALL hold its value; the FSM returns to IDLE when start=0.
REQ-023 A start assertion outside IDLE SHALL be ignored; start held high through DONE SHALL NOT retrigger a run.
REQ-024 end_process bits outside the latched mask SHALL be ignored.
REQ-025 Latency SHALL be: start high at edge N gives status=01 after edge N; the last end_process bit at edge M gives done=1 after edge M+1.

Reset
REQ-026 On reset, the FSM SHALL enter IDLE and status, end_core, busy, done, error, cycle_count, seen_mask and the latched mask SHALL all be 0.
REQ-027 Reset SHALL take effect from any state, including mid-START, mid-RUN and mid-ABORT, with no residual abort code on end_core.

Configuration
REQ-028 With macro CORE_SYNC_CYCLE_CNT_EN defined, cycle_count SHALL clear on entering START, increment in START, RUN and ABORT, saturate at all-ones, and freeze in DONE and IDLE.
REQ-029 Without CORE_SYNC_CYCLE_CNT_EN, the cycle_count port SHALL remain and be tied to 0; the timeout counter is unaffected.

Structure
REQ-030 Package core_sync_pkg SHALL hold the FSM state enum, the STATUS_IDLE, STATUS_GO and STATUS_DONE encodings, and END_CORE_ABORT=2'b10.
REQ-031 One sub-module, run_timer, SHALL hold the timeout counter and the optional cycle counter; the FSM and mask tracking SHALL remain in the top module.

Verification
REQ-032 Mask 4'b1111, start=1, end_process bits rising at RUN cycles 5, 9, 12 and 20 -> done=1 one cycle after the last bit, error=0, status=10.
REQ-033 TIMEOUT=50, core 2 never ends -> end_core=10 from RUN cycle 50; end_process[2] then rising -> DONE with error=1.
REQ-034 Mask 4'b0101 with end_process[1] stuck high -> no DONE until bits 0 and 2 have both been seen.
REQ-035 Reset pulsed in RUN cycle 7 and again in ABORT -> all outputs 0 on the next cycle, FSM in IDLE.
REQ-036 Mask 0 -> DONE after START_HOLD+1 cycles; start held high through DONE -> no second run; start dropped -> IDLE.
REQ-037 With CORE_SYNC_CYCLE_CNT_EN and TIMEOUT=0, a 100-cycle run -> cycle_count=START_HOLD+100 frozen in DONE; without the macro -> cycle_count=0.

Source files
------------

// File: rtl/core_sync_pkg.sv
// rtl/core_sync_pkg.sv - shared state and status encodings for the core sync controller
package core_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_ABORT,
        ST_DONE
    } state_t;

    localparam logic [1:0] STATUS_IDLE    = 2'b00;
    localparam logic [1:0] STATUS_GO      = 2'b01;
    localparam logic [1:0] STATUS_DONE    = 2'b10;

    localparam logic [1:0] END_CORE_NONE  = 2'b00;
    localparam logic [1:0] END_CORE_ABORT = 2'b10;

endpackage

// File: rtl/core_sync_controller_if.sv
// rtl/core_sync_controller_if.sv - host/core handshake bundle for the core sync controller
interface core_sync_controller_if #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 32
);
    logic                 start;
    logic [NUM_CORES-1:0] core_mask;
    logic [NUM_CORES-1:0] end_process;
    logic [1:0]           status;
    logic [1:0]           end_core;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [CNT_W-1:0]     cycle_count;

    modport master (
        output start, core_mask, end_process,
        input  status, end_core, busy, done, error, cycle_count
    );

    modport slave (
        input  start, core_mask, end_process,
        output status, end_core, busy, done, error, cycle_count
    );
endinterface

// File: rtl/core_sync_controller_run_timer.sv
// rtl/core_sync_controller_run_timer.sv - run timeout counter and optional cycle counter (CORE_SYNC_CYCLE_CNT_EN)
module run_timer #(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             run_active,
    input  logic             count_active,
    output logic             timeout_hit,
    output logic [CNT_W-1:0] cycle_count
);
    // With TIMEOUT=0 this is all-ones; the counter just parks there and never fires.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_q;

    // Timeout counter: counts RUN cycles only, parks at its limit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            tmo_q <= '0;
        end else if (run_active && (tmo_q != TMO_LAST)) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && run_active && (tmo_q == TMO_LAST);

`ifdef CORE_SYNC_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q;

    // Cycle counter: runs through START/RUN/ABORT, saturates, frozen elsewhere.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cyc_q <= '0;
        end else if (count_active && (cyc_q != {CNT_W{1'b1}})) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign cycle_count = cyc_q;
`else
    logic unused_count_active;
    assign unused_count_active = count_active;
    assign cycle_count = '0;
`endif

endmodule

// File: rtl/core_sync_controller.sv
// rtl/core_sync_controller.sv - run/abort sequencer for a group of cores; optional cycle count via CORE_SYNC_CYCLE_CNT_EN
module core_sync_controller
    import core_sync_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 1000,
    parameter int CNT_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    core_sync_controller_if.slave  bus
);
    localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

    state_t               state;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] seen_q;
    logic [NUM_CORES-1:0] seen_next;
    logic                 all_seen;
    logic [3:0]           hold_q;
    logic [1:0]           status_q;
    logic [1:0]           end_core_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 start_run;
    logic                 run_active;
    logic                 count_active;
    logic                 timeout_hit;

    // Completion looks at this cycle's end flags so done follows the last flag by one edge.
    assign seen_next    = seen_q | (bus.end_process & mask_q);
    assign all_seen     = (seen_next == mask_q);
    assign start_run    = (state == ST_IDLE) && bus.start;
    assign run_active   = (state == ST_RUN);
    assign count_active = (state == ST_START) || (state == ST_RUN) || (state == ST_ABORT);

    run_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_run_timer (
        .clock        (clock),
        .reset        (reset),
        .clear        (start_run),
        .run_active   (run_active),
        .count_active (count_active),
        .timeout_hit  (timeout_hit),
        .cycle_count  (bus.cycle_count)
    );

    // Run sequencer with mask tracking and registered broadcast outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            mask_q     <= '0;
            seen_q     <= '0;
            hold_q     <= '0;
            status_q   <= STATUS_IDLE;
            end_core_q <= END_CORE_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_START;
                        mask_q     <= bus.core_mask;
                        seen_q     <= '0;
                        hold_q     <= '0;
                        status_q   <= STATUS_GO;
                        end_core_q <= END_CORE_NONE;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    seen_q <= seen_next;
                    if (hold_q == HOLD_LAST) begin
                        state    <= ST_RUN;
                        status_q <= STATUS_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    seen_q <= seen_next;
                    // Completion beats a coincident timeout.
                    if (all_seen) begin
                        state    <= ST_DONE;
                        status_q <= STATUS_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        error_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        state      <= ST_ABORT;
                        end_core_q <= END_CORE_ABORT;
                    end
                end
                ST_ABORT: begin
                    seen_q <= seen_next;
                    // Stay here until every participating core has reached endop.
                    if (all_seen) begin
                        state      <= ST_DONE;
                        status_q   <= STATUS_DONE;
                        end_core_q <= END_CORE_NONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        error_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.start) begin
                        state    <= ST_IDLE;
                        status_q <= STATUS_IDLE;
                        done_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.status   = status_q;
    assign bus.end_core = end_core_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_core_sync_controller.sv
// tb/tb_core_sync_controller.sv - randomized self-checking bench for core_sync_controller
module tb_core_sync_controller;

    localparam int NC    = 4;
    localparam int SH    = 2;
    localparam int TMO_A = 50;
    localparam int TMO_B = 0;
    localparam int CW    = 32;
    localparam int NEVER = 100000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NC-1:0] core_mask;
    logic [NC-1:0] end_process;

    int tests_run = 0;
    int tests_failed = 0;

    core_sync_controller_if #(.NUM_CORES(NC), .CNT_W(CW)) bus_a ();
    core_sync_controller_if #(.NUM_CORES(NC), .CNT_W(CW)) bus_b ();

    assign bus_a.start       = start;
    assign bus_a.core_mask   = core_mask;
    assign bus_a.end_process = end_process;
    assign bus_b.start       = start;
    assign bus_b.core_mask   = core_mask;
    assign bus_b.end_process = end_process;

    core_sync_controller #(.NUM_CORES(NC), .START_HOLD(SH), .TIMEOUT(TMO_A), .CNT_W(CW)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    core_sync_controller #(.NUM_CORES(NC), .START_HOLD(SH), .TIMEOUT(TMO_B), .CNT_W(CW)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clock = ~clock;

    // Edges are numbered from the one that samples start in IDLE (edge 0).
    // c is the edge at which the last masked end flag is first sampled.
    function automatic int finish_edge(input int c);
        return (c > SH + 1) ? c : SH + 1;
    endfunction

    function automatic bit aborted(input int c, input int tmo);
        return (tmo != 0) && (finish_edge(c) > SH + tmo);
    endfunction

    // Expected {status, end_core, busy, done} just after edge k.
    function automatic logic [5:0] exp_vec(input int k, input int c, input int tmo);
        int fin;
        fin = finish_edge(c);
        if (k < SH)
            return 6'b01_00_1_0;
        else if (k < fin)
            return (aborted(c, tmo) && (k >= SH + tmo)) ? 6'b00_10_1_0 : 6'b00_00_1_0;
        else
            return 6'b10_00_0_1;
    endfunction

    function automatic logic [CW-1:0] exp_count(input int c);
`ifdef CORE_SYNC_CYCLE_CNT_EN
        return CW'(finish_edge(c));
`else
        return '0;
`endif
    endfunction

    function automatic logic [NC-1:0] ep_for(input int j, input logic [NC-1:0] m, input int t[NC], input bit stuck);
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) begin
            if (m[i]) v[i] = (j >= t[i]);
            else      v[i] = stuck ? 1'b1 : 1'($urandom_range(0, 1));
        end
        return v;
    endfunction

    task automatic do_run(input string name, input logic [NC-1:0] m,
                          input int t0, input int t1, input int t2, input int t3, input bit stuck);
        int t[NC];
        int c;
        int last;
        logic [5:0] got;
        logic [5:0] exp;
        t = '{t0, t1, t2, t3};
        c = 0;
        for (int i = 0; i < NC; i++)
            if (m[i] && t[i] > c) c = t[i];
        last = finish_edge(c) + 3;
        @(negedge clock);
        start       = 1'b1;
        core_mask   = m;
        end_process = NC'($urandom);
        for (int k = 0; k <= last; k++) begin
            @(posedge clock);
            @(negedge clock);
            got = {bus_a.status, bus_a.end_core, bus_a.busy, bus_a.done};
            exp = exp_vec(k, c, TMO_A);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s dut_a outputs edge %0d: got %b expected %b", name, k, got, exp);
            end
            got = {bus_b.status, bus_b.end_core, bus_b.busy, bus_b.done};
            exp = exp_vec(k, c, TMO_B);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s dut_b outputs edge %0d: got %b expected %b", name, k, got, exp);
            end
            core_mask   = NC'($urandom);
            end_process = ep_for(k + 1, m, t, stuck);
        end
        tests_run++;
        if (bus_a.error !== aborted(c, TMO_A)) begin
            tests_failed++;
            $display("FAIL %s dut_a error: got %b expected %b", name, bus_a.error, aborted(c, TMO_A));
        end
        tests_run++;
        if (bus_b.error !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s dut_b error: got %b expected 0", name, bus_b.error);
        end
        tests_run++;
        if (bus_a.cycle_count !== exp_count(c)) begin
            tests_failed++;
            $display("FAIL %s dut_a cycle_count: got %0d expected %0d", name, bus_a.cycle_count, exp_count(c));
        end
        tests_run++;
        if (bus_b.cycle_count !== exp_count(c)) begin
            tests_failed++;
            $display("FAIL %s dut_b cycle_count: got %0d expected %0d", name, bus_b.cycle_count, exp_count(c));
        end
        start       = 1'b0;
        end_process = '0;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({bus_a.status, bus_a.end_core, bus_a.busy, bus_a.done, bus_b.status, bus_b.end_core, bus_b.busy, bus_b.done} !== 12'h0) begin
            tests_failed++;
            $display("FAIL %s return to idle: got a=%b%b%b%b b=%b%b%b%b expected all 0", name,
                     bus_a.status, bus_a.end_core, bus_a.busy, bus_a.done,
                     bus_b.status, bus_b.end_core, bus_b.busy, bus_b.done);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({bus_a.status, bus_a.end_core, bus_a.busy, bus_a.done, bus_a.error, bus_a.cycle_count} !== '0) begin
            tests_failed++;
            $display("FAIL %s dut_a outputs: got st=%b ec=%b busy=%b done=%b err=%b cnt=%0d expected all 0", name,
                     bus_a.status, bus_a.end_core, bus_a.busy, bus_a.done, bus_a.error, bus_a.cycle_count);
        end
        tests_run++;
        if ({bus_b.status, bus_b.end_core, bus_b.busy, bus_b.done, bus_b.error, bus_b.cycle_count} !== '0) begin
            tests_failed++;
            $display("FAIL %s dut_b outputs: got st=%b ec=%b busy=%b done=%b err=%b cnt=%0d expected all 0", name,
                     bus_b.status, bus_b.end_core, bus_b.busy, bus_b.done, bus_b.error, bus_b.cycle_count);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b0;
        core_mask   = '0;
        end_process = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("reset");
    endtask

    // Runs with no end flags for 'edges' edges, then resets in whatever state that is.
    task automatic test_reset_mid(input string name, input int edges);
        logic [5:0] got;
        logic [5:0] exp;
        @(negedge clock);
        start       = 1'b1;
        core_mask   = 4'hF;
        end_process = '0;
        repeat (edges) @(posedge clock);
        @(negedge clock);
        got = {bus_a.status, bus_a.end_core, bus_a.busy, bus_a.done};
        exp = exp_vec(edges - 1, NEVER, TMO_A);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s pre-reset dut_a: got %b expected %b", name, got, exp);
        end
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all_zero(name);
    endtask

    task automatic test_all_cores();
        do_run("all_cores", 4'b1111, SH + 1 + 5, SH + 1 + 9, SH + 1 + 12, SH + 1 + 20, 1'b0);
    endtask

    task automatic test_timeout();
        do_run("timeout", 4'b1111, SH + 1 + 3, SH + 1 + 10, SH + 1 + 70, SH + 1 + 20, 1'b0);
    endtask

    task automatic test_timeout_tie();
        do_run("timeout_tie", 4'b0011, 5, SH + TMO_A, 1, 1, 1'b0);
    endtask

    task automatic test_unmasked();
        do_run("unmasked", 4'b0101, SH + 1 + 4, 1, SH + 1 + 9, 1, 1'b1);
    endtask

    task automatic test_mask_zero();
        do_run("mask_zero", 4'b0000, 1, 1, 1, 1, 1'b1);
    endtask

    task automatic test_cycle_count();
        do_run("cycle_count", 4'b0001, SH + 100, 1, 1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 12; n++) begin
            do_run("random", NC'($urandom_range(0, 15)),
                   $urandom_range(1, 80), $urandom_range(1, 80),
                   $urandom_range(1, 80), $urandom_range(1, 80),
                   1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_all_cores();
        test_timeout();
        test_timeout_tie();
        test_unmasked();
        test_mask_zero();
        test_cycle_count();
        test_reset_mid("reset_start", 1);
        test_reset_mid("reset_run7", SH + 8);
        test_reset_mid("reset_abort", SH + TMO_A + 5);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
